// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and the (x,y) -> linear address helper for
// the 200x150 framebuffer arbiter.
package fb_pkg;

    localparam int PIXW   = 8;
    localparam int HRES   = 200;
    localparam int VRES   = 150;
    localparam int VSHIFT = 2;
    localparam int ADDRW  = 15;

    localparam logic [ADDRW-1:0] CLR_LAST = ADDRW'(HRES * VRES - 1);

    localparam int OWN_SCAN = 0;
    localparam int OWN_CLR  = 1;
    localparam int OWN_WR   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // y*200 + x as shift-and-add: 200 = 128 + 64 + 8
    function automatic logic [ADDRW-1:0] xy2addr(input logic [7:0] x, input logic [7:0] y);
        logic [ADDRW-1:0] yw;
        logic [ADDRW-1:0] xw;
        yw = ADDRW'(y);
        xw = ADDRW'(x);
        return (yw << 7) + (yw << 6) + (yw << 3) + xw;
    endfunction

endpackage

// File: rtl/fb_xy2addr.sv
// Combinational pixel-coordinate to framebuffer-address mapper.
module fb_xy2addr
    import fb_pkg::*;
(
    input  logic [7:0]       x_i,
    input  logic [7:0]       y_i,
    output logic [ADDRW-1:0] addr_o
);

    assign addr_o = xy2addr(x_i, y_i);

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: scan-out owns the RAM during active video, the
// clear engine or the draw writer get it during blanking.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       hcounter,
    input  logic [10:0]      vcounter,
    input  logic             display,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic [PIXW-1:0]  wr_data,
    input  logic             clr_start,
    input  logic [PIXW-1:0]  clr_color,
    output logic             busy,
    output logic             clr_done,
    output logic [15:0]      drop_cnt,
    output logic [ADDRW-1:0] ram_addr,
    output logic             ram_we,
    output logic [PIXW-1:0]  ram_wdata,
    input  logic [PIXW-1:0]  ram_rdata,
    output logic [PIXW-1:0]  pixel,
    output logic             pixel_de,
    output logic             hsync_o,
    output logic             vsync_o
);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] clrAddr_q, clrAddr_d;
    logic [PIXW-1:0]  clrColor_q, clrColor_d;
    logic [15:0]      dropCnt_q, dropCnt_d;
    logic [1:0]       deDly_q, hsDly_q, vsDly_q;
    logic [PIXW-1:0]  pixel_q;

    logic [2:0]       owner;
    logic [10:0]      scanRow;
    logic [ADDRW-1:0] scanAddr, wrAddr;
    logic             wrFire, wrInRange, clrLast;
    logic             unusedBits;

    // Each framebuffer row is shown on 2^VSHIFT consecutive scan lines
    assign scanRow    = vcounter >> VSHIFT;
    assign unusedBits = ^{hcounter[8], scanRow[10:8]};

    fb_xy2addr u_scanMap (
        .x_i    (hcounter[7:0]),
        .y_i    (scanRow[7:0]),
        .addr_o (scanAddr)
    );

    fb_xy2addr u_wrMap (
        .x_i    (wr_x),
        .y_i    (wr_y),
        .addr_o (wrAddr)
    );

    always_comb begin
        owner = '0;
        if (display) begin
            owner[OWN_SCAN] = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            owner[OWN_CLR] = 1'b1;
        end else begin
            owner[OWN_WR] = 1'b1;
        end
    end

    assign wr_ready  = rst_n & owner[OWN_WR];
    assign wrFire    = wr_valid & wr_ready;
    assign wrInRange = (wr_x < 8'(HRES)) && (wr_y < 8'(VRES));
    assign clrLast   = owner[OWN_CLR] && (clrAddr_q == CLR_LAST);

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (owner[OWN_SCAN]) begin
            ram_addr = scanAddr;
        end else if (owner[OWN_CLR]) begin
            ram_addr  = clrAddr_q;
            ram_we    = rst_n;
            ram_wdata = clrColor_q;
        end else begin
            ram_addr  = wrAddr;
            ram_we    = wrFire & wrInRange;
            ram_wdata = wr_data;
        end
    end

    // Clear counter only advances on cycles where the clear engine owns the port
    always_comb begin
        state_d    = state_q;
        clrAddr_d  = clrAddr_q;
        clrColor_d = clrColor_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    clrAddr_d  = '0;
                    clrColor_d = clr_color;
                end
            end
            ST_CLEAR: begin
                if (owner[OWN_CLR]) begin
                    if (clrLast) begin
                        state_d   = ST_IDLE;
                        clrAddr_d = '0;
                    end else begin
                        clrAddr_d = clrAddr_q + ADDRW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (wrFire && !wrInRange && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clrAddr_q  <= '0;
            clrColor_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            clrAddr_q  <= clrAddr_d;
            clrColor_q <= clrColor_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Two-stage delay matches the address cycle plus the RAM read cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deDly_q <= 2'b00;
            hsDly_q <= 2'b11;
            vsDly_q <= 2'b11;
            pixel_q <= '0;
        end else begin
            deDly_q <= {deDly_q[0], display};
            hsDly_q <= {hsDly_q[0], hsync_in};
            vsDly_q <= {vsDly_q[0], vsync_in};
            pixel_q <= deDly_q[0] ? ram_rdata : '0;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_done = clrLast;
    assign drop_cnt = dropCnt_q;
    assign pixel    = pixel_q;
    assign pixel_de = deDly_q[1];
    assign hsync_o  = hsDly_q[1];
    assign vsync_o  = vsDly_q[1];

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: stimulus pushes expected RAM writes and
// scan-out pixels, a negedge monitor pops and compares them.
module tb_fb_arbiter;

    localparam int W     = 200;
    localparam int H     = 150;
    localparam int NPIX  = W * H;

    typedef struct {
        int addr;
        int data;
        bit last;
        bit isClr;
    } wr_exp_t;

    typedef struct {
        bit chk;
        int val;
    } pix_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  hcounter;
    logic [10:0] vcounter;
    logic        display, hsync_in, vsync_in;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x, wr_y, wr_data;
    logic        clr_start;
    logic [7:0]  clr_color;
    logic        busy, clr_done;
    logic [15:0] drop_cnt;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  pixel;
    logic        pixel_de, hsync_o, vsync_o;

    fb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcounter  (hcounter),
        .vcounter  (vcounter),
        .display   (display),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .busy      (busy),
        .clr_done  (clr_done),
        .drop_cnt  (drop_cnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pixel     (pixel),
        .pixel_de  (pixel_de),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, preloaded with addr[7:0] on the first edge
    logic [7:0] mem [0:32767];
    bit preDone = 1'b0;
    always @(posedge clk) begin
        if (!preDone) begin
            for (int a = 0; a < 32768; a++) mem[a] <= 8'(a);
            preDone <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    logic [7:0] refMem [0:32767];
    wr_exp_t    wrQ[$];
    pix_exp_t   pixQ[$];
    int  checkCnt = 0;
    int  passCnt  = 0;
    int  failCnt  = 0;
    bit  expBusy  = 1'b0;
    bit  busyPend = 1'b0;
    int  expDrop  = 0;
    int  expDropNext = 0;
    int  clrSeen  = 0;
    bit  pixChk   = 1'b1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCnt++;
        if (actual == expected) begin
            passCnt++;
        end else begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares everything the DUT presents each cycle against the scoreboard
    wr_exp_t    monW;
    pix_exp_t   monP;
    bit         doneExp;
    logic [1:0] deH = 2'b00;
    logic [1:0] hsH = 2'b11;
    logic [1:0] vsH = 2'b11;

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_pixel", int'(pixel), 0);
            checkOutput("rst_pixel_de", int'(pixel_de), 0);
            checkOutput("rst_hsync_o", int'(hsync_o), 1);
            checkOutput("rst_vsync_o", int'(vsync_o), 1);
            checkOutput("rst_busy", int'(busy), 0);
            checkOutput("rst_clr_done", int'(clr_done), 0);
            checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
            checkOutput("rst_ram_we", int'(ram_we), 0);
            checkOutput("rst_wr_ready", int'(wr_ready), 0);
            deH = 2'b00;
            hsH = 2'b11;
            vsH = 2'b11;
        end else begin
            checkOutput("wr_ready", int'(wr_ready), int'(!display && !expBusy));
            checkOutput("busy", int'(busy), int'(expBusy));
            if (display) checkOutput("we_in_display", int'(ram_we), 0);
            doneExp = 1'b0;
            if (ram_we) begin
                checkOutput("write_expected", int'(wrQ.size() > 0), 1);
                if (wrQ.size() > 0) begin
                    monW = wrQ.pop_front();
                    checkOutput("ram_addr", int'(ram_addr), monW.addr);
                    checkOutput("ram_wdata", int'(ram_wdata), monW.data);
                    doneExp = monW.last;
                    if (monW.isClr) clrSeen++;
                end
            end
            checkOutput("clr_done", int'(clr_done), int'(doneExp));
            checkOutput("drop_cnt", int'(drop_cnt), expDrop);
            checkOutput("pixel_de", int'(pixel_de), int'(deH[1]));
            checkOutput("hsync_o", int'(hsync_o), int'(hsH[1]));
            checkOutput("vsync_o", int'(vsync_o), int'(vsH[1]));
            if (pixel_de) begin
                checkOutput("pixel_expected", int'(pixQ.size() > 0), 1);
                if (pixQ.size() > 0) begin
                    monP = pixQ.pop_front();
                    if (monP.chk) checkOutput("pixel", int'(pixel), monP.val);
                end
            end else begin
                checkOutput("pixel_blank", int'(pixel), 0);
            end
            deH = {deH[0], display};
            hsH = {hsH[0], hsync_in};
            vsH = {vsH[0], vsync_in};
            expDrop = expDropNext;
            if (doneExp) expBusy = 1'b0;
            if (busyPend) begin
                expBusy  = 1'b1;
                busyPend = 1'b0;
            end
        end
    end

    // One cycle of stimulus; the reference model decides acceptance and queues expectations
    task automatic applyStimulus(input bit disp, input int h, input int v, input bit wv,
                                 input int x, input int y, input int d,
                                 input bit cs, input int cc, output bit acc);
        wr_exp_t  we;
        pix_exp_t pe;
        @(posedge clk);
        #1;
        display   = disp;
        hcounter  = 9'(h);
        vcounter  = 11'(v);
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        wr_valid  = wv;
        wr_x      = 8'(x);
        wr_y      = 8'(y);
        wr_data   = 8'(d);
        clr_start = cs;
        clr_color = 8'(cc);
        acc = wv && !disp && !expBusy;
        if (disp) begin
            pe.chk = pixChk;
            pe.val = int'(refMem[(v / 4) * W + h]);
            pixQ.push_back(pe);
        end
        if (acc) begin
            if (x < W && y < H) begin
                we.addr  = y * W + x;
                we.data  = d;
                we.last  = 1'b0;
                we.isClr = 1'b0;
                wrQ.push_back(we);
                refMem[y * W + x] = 8'(d);
            end else if (expDropNext < 65535) begin
                expDropNext++;
            end
        end
        if (cs && !expBusy && !busyPend) begin
            busyPend = 1'b1;
            for (int a = 0; a < NPIX; a++) begin
                we.addr  = a;
                we.data  = cc;
                we.last  = (a == NPIX - 1);
                we.isClr = 1'b1;
                wrQ.push_back(we);
                refMem[a] = 8'(cc);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic randCycle(input bit wv, input int x, input int y, input int d,
                             input bit cs, input int cc, input int prob, output bit acc);
        bit disp;
        disp = ($urandom_range(0, 99) < prob);
        applyStimulus(disp, $urandom_range(0, W - 1), $urandom_range(0, 599),
                      wv, x, y, d, cs, cc, acc);
    endtask

    task automatic doWrite(input int x, input int y, input int d, input int prob);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            randCycle(1'b1, x, y, d, 1'b0, 0, prob, acc);
            n++;
        end
        if (!acc) checkOutput("write_accept_timeout", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0, acc);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        display   = 1'b0;
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        wrQ.delete();
        pixQ.delete();
        expBusy     = 1'b0;
        busyPend    = 1'b0;
        expDrop     = 0;
        expDropNext = 0;
        clrSeen     = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic scanLine(input int v);
        bit acc;
        for (int h = 0; h < W; h++) applyStimulus(1'b1, h, v, 1'b0, 0, 0, 0, 1'b0, 0, acc);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d so far", passCnt, checkCnt);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int n;
        rst_n = 1'b0;
        hcounter = '0; vcounter = '0; display = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clr_start = 1'b0; clr_color = '0;
        for (int a = 0; a < 32768; a++) refMem[a] = 8'(a);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        $display("[TB] scan-out of preloaded frame");
        for (int v = 0; v < 8; v++) scanLine(v);
        idle(4);

        $display("[TB] write held off by active video");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, $urandom_range(0, W - 1), $urandom_range(0, 599),
                          1'b1, 10, 3, 8'hA5, 1'b0, 0, acc);
        doWrite(10, 3, 8'hA5, 0);
        idle(2);

        $display("[TB] out-of-range drops and random writes");
        doWrite(200, 0, 8'h11, 0);
        doWrite(0, 150, 8'h22, 0);
        for (int i = 0; i < 60; i++)
            doWrite($urandom_range(0, W + 9), $urandom_range(0, H + 9), $urandom_range(0, 255), 30);
        idle(2);

        $display("[TB] drop counter saturation");
        force dut.dropCnt_q = 16'hFFFE;
        expDrop     = 16'hFFFE;
        expDropNext = 16'hFFFE;
        idle(2);
        release dut.dropCnt_q;
        doWrite(255, 0, 0, 0);
        doWrite(0, 255, 0, 0);
        idle(2);

        $display("[TB] reset in the middle of a clear");
        pixChk = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 8'h11, acc);
        n = 0;
        while (clrSeen < 1234 && n < 5000) begin
            randCycle(1'b0, 0, 0, 0, 1'b0, 0, 20, acc);
            n++;
        end
        if (clrSeen < 1234) checkOutput("partial_clear_timeout", clrSeen, 1234);
        doReset();
        idle(2);

        $display("[TB] full clear started alongside an accepted write");
        applyStimulus(1'b0, 0, 0, 1'b1, 1, 0, 8'h5A, 1'b1, 8'h3C, acc);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60000) begin
            randCycle(1'b1, 5, 5, 8'h77, (clrSeen < 29000) && ($urandom_range(0, 999) == 0),
                      8'hEE, 20, acc);
            n++;
        end
        if (!acc) checkOutput("clear_finish_timeout", int'(acc), 1);
        n = 0;
        while (wrQ.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);

        $display("[TB] scan-out after clear");
        pixChk = 1'b1;
        scanLine(0);
        scanLine(20);
        scanLine(599);
        idle(4);

        checkOutput("write_queue_drained", wrQ.size(), 0);
        checkOutput("pixel_queue_drained", pixQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
